pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the hold and clear controls of the PC, IF/ID and ID/EX pipeline registers, and sequences the multi-cycle multiply/divide unit that writes HI/LO. It resolves three conditions with fixed priority: EX-stage redirect, load-use hazards, and HI/LO/multiply-divide busy hazards. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MUL_CYCLES, 4: multiply occupancy in cycles, ≥1
- DIV_CYCLES, 32: divide occupancy in cycles, ≥1
- CNT_W, 32: StallCount width
- clk  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high
- ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID
- ID_UseRs, ID_UseRt  in  1 each  ID instruction actually reads Rs/Rt
- ID_MulDiv  in  1  ID instruction is mult/multu/div/divu
- ID_IsDiv  in  1  qualifies ID_MulDiv: 1 = divide
- ID_ReadHILO  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- EX_RegWrite, EX_MemtoReg  in  1 each  EX instruction writes a register from memory (load)
- EX_WbRegNum  in  5  EX destination register
- EX_Redirect  in  1  taken branch/jump resolved in EX
- PC_Stall  out  1  hold PC
- IFID_Stall  out  1  hold IF/ID
- IFID_CLR  out  1  clear IF/ID (drives its CLR)
- IDEX_CLR  out  1  clear ID/EX (bubble)
- MD_Start  out  1  one-cycle start pulse to multiply/divide unit
- MD_IsDiv  out  1  latched operation type of the running operation
- MD_Busy  out  1  multiply/divide unit occupied
- MD_Done  out  1  one-cycle HI/LO write strobe
- StallCount  out  CNT_W  saturating count of stall cycles

## Operation
- lu_hazard = EX_RegWrite & EX_MemtoReg & (EX_WbRegNum≠0) & ((ID_UseRs & ID_Rs==EX_WbRegNum) | (ID_UseRt & ID_Rt==EX_WbRegNum)).
- md_hazard = (state≠IDLE) & (ID_MulDiv | ID_ReadHILO).
- stall = lu_hazard | md_hazard.
- Priority 1, EX_Redirect=1:
  - IFID_CLR=1, IDEX_CLR=1, PC_Stall=IFID_Stall=0.
  - The stall is ignored because the ID instruction is wrong-path.
- Priority 2, stall=1 and no redirect: PC_Stall=IFID_Stall=1, IDEX_CLR=1, IFID_CLR=0.
- Otherwise all four controls are 0.
- Multiply/divide FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY when ID_MulDiv & ~lu_hazard & ~EX_Redirect.
    - On that edge: cnt ← (ID_IsDiv ? DIV_CYCLES : MUL_CYCLES) − 1, MD_IsDiv ← ID_IsDiv, MD_Start ← 1.
  - BUSY: MD_Start ← 0. If cnt==0 then →DONE, else cnt ← cnt−1.
  - DONE: MD_Done=1 for exactly one cycle, then →IDLE unconditionally.
  - A new issue is not possible in DONE, because md_hazard holds it.
- An issued operation is never cancelled by EX_Redirect: it is older than the branch.
- StallCount increments by 1 on each edge where stall & ~EX_Redirect, and saturates at all-ones.
- Register 0 never causes a hazard.
- Simultaneous lu_hazard and md_hazard produce a single stall cycle, counted once.

## Timing
- Reset (CLR high, async):
  - state=IDLE, cnt=0.
  - MD_Start=MD_IsDiv=MD_Busy=MD_Done=0, StallCount=0.
  - Combinational outputs follow inputs with state=IDLE.
- PC_Stall, IFID_Stall, IFID_CLR and IDEX_CLR are combinational from the current-cycle inputs and state.
- MD_Start, MD_IsDiv, MD_Busy (state==BUSY), MD_Done (state==DONE) and StallCount are registered.
- Latency, with issue at edge 0:
  - MD_Start and MD_Busy are high in cycle 1.
  - MD_Busy is high in cycles 1..N, where N is MUL_CYCLES or DIV_CYCLES.
  - MD_Done is high in cycle N+1.
  - IDLE in cycle N+2. A dependent mfhi held in ID issues into EX at the end of cycle N+2.
- Back-to-back multiply/divide: the second waits in ID until IDLE, then issues on the next edge.
- CLR asserted mid-operation: the FSM returns to IDLE immediately. MD_Done is never asserted for the aborted operation.

## Test plan
- **Load-use:** EX lw to $5 with ID reading Rs=$5 → PC_Stall=IFID_Stall=IDEX_CLR=1 for 1 cycle, StallCount 0→1. Repeat with EX_WbRegNum=0 → no stall.
- **Multiply issue + mfhi:** issue mult with MUL_CYCLES=4 at edge 0, mfhi in ID from cycle 1 →
  - MD_Start high in cycle 1 only, MD_Busy high in cycles 1–4, MD_Done high in cycle 5.
  - Stall in cycles 1–5, release in cycle 6, StallCount=5.
- **Divide:** DIV_CYCLES=32, MD_IsDiv=1 → MD_Done exactly at cycle 33, MD_IsDiv held stable throughout.
- **Redirect priority:** EX_Redirect with simultaneous load-use and an ID mult in IDLE →
  - IFID_CLR=IDEX_CLR=1, no stall, no issue, StallCount unchanged.
  - EX_Redirect during BUSY → operation still completes with MD_Done.
- **Reset mid-divide:** assert CLR at cycle 10 of a divide → all registered outputs 0 asynchronously, no MD_Done afterwards, StallCount=0.
- **Saturation:** CNT_W=4 with continuous md_hazard for 20 cycles → StallCount stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: redirect flush, load-use and
// HI/LO hazard stalls, multiply/divide sequencing and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic             ID_MulDiv,
    input  logic             ID_IsDiv,
    input  logic             ID_ReadHILO,
    input  logic             EX_RegWrite,
    input  logic             EX_MemtoReg,
    input  logic [4:0]       EX_WbRegNum,
    input  logic             EX_Redirect,
    output logic             PC_Stall,
    output logic             IFID_Stall,
    output logic             IFID_CLR,
    output logic             IDEX_CLR,
    output logic             MD_Start,
    output logic             MD_IsDiv,
    output logic             MD_Busy,
    output logic             MD_Done,
    output logic [CNT_W-1:0] StallCount
);

    localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic             md_start_r;
    logic             md_isdiv_r;
    logic             md_busy_r;
    logic             md_done_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic lu_hazard_s;
    logic md_hazard_s;
    logic stall_s;
    logic issue_s;

    // Hazard detection; register 0 is hardwired and never creates a dependency.
    always_comb begin
        lu_hazard_s = 1'b0;
        if (EX_RegWrite && EX_MemtoReg && (EX_WbRegNum != 5'd0)) begin
            lu_hazard_s = (ID_UseRs && (ID_Rs == EX_WbRegNum)) ||
                          (ID_UseRt && (ID_Rt == EX_WbRegNum));
        end else begin
            lu_hazard_s = 1'b0;
        end
        md_hazard_s = (state_r != ST_IDLE) && (ID_MulDiv || ID_ReadHILO);
        stall_s     = lu_hazard_s || md_hazard_s;
        issue_s     = (state_r == ST_IDLE) && ID_MulDiv && !lu_hazard_s && !EX_Redirect;
    end

    // Pipeline register controls; a redirect wins because the ID instruction is wrong-path.
    always_comb begin
        PC_Stall   = 1'b0;
        IFID_Stall = 1'b0;
        IFID_CLR   = 1'b0;
        IDEX_CLR   = 1'b0;
        if (EX_Redirect) begin
            IFID_CLR = 1'b1;
            IDEX_CLR = 1'b1;
        end else if (stall_s) begin
            PC_Stall   = 1'b1;
            IFID_Stall = 1'b1;
            IDEX_CLR   = 1'b1;
        end else begin
            PC_Stall   = 1'b0;
            IFID_Stall = 1'b0;
        end
    end

    // Multiply/divide sequencer; an issued operation is never cancelled by a redirect.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            md_start_r <= 1'b0;
            md_isdiv_r <= 1'b0;
            md_busy_r  <= 1'b0;
            md_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    md_done_r <= 1'b0;
                    if (issue_s) begin
                        state_r    <= ST_BUSY;
                        cnt_r      <= ID_IsDiv ? DIV_LOAD : MUL_LOAD;
                        md_isdiv_r <= ID_IsDiv;
                        md_start_r <= 1'b1;
                        md_busy_r  <= 1'b1;
                    end else begin
                        md_start_r <= 1'b0;
                        md_busy_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    md_start_r <= 1'b0;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r   <= ST_DONE;
                        md_busy_r <= 1'b0;
                        md_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    md_done_r <= 1'b0;
                    md_busy_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= {CW{1'b0}};
                    md_start_r <= 1'b0;
                    md_busy_r  <= 1'b0;
                    md_done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter; redirect cycles are flushes, not stalls.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && !EX_Redirect && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign MD_Start   = md_start_r;
    assign MD_IsDiv   = md_isdiv_r;
    assign MD_Busy    = md_busy_r;
    assign MD_Done    = md_done_r;
    assign StallCount = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl against a timeline-based model.
module tb_pipeline_hazard_ctrl;

    localparam int MULC   = 4;
    localparam int DIVC   = 32;
    localparam int CW     = 4;
    localparam int NCYC   = 4000;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk;
    logic          CLR;
    logic [4:0]    ID_Rs, ID_Rt, EX_WbRegNum;
    logic          ID_UseRs, ID_UseRt, ID_MulDiv, ID_IsDiv, ID_ReadHILO;
    logic          EX_RegWrite, EX_MemtoReg, EX_Redirect;
    logic          PC_Stall, IFID_Stall, IFID_CLR, IDEX_CLR;
    logic          MD_Start, MD_IsDiv, MD_Busy, MD_Done;
    logic [CW-1:0] StallCount;

    pipeline_hazard_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
        .clk(clk), .CLR(CLR),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_MulDiv(ID_MulDiv), .ID_IsDiv(ID_IsDiv), .ID_ReadHILO(ID_ReadHILO),
        .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_WbRegNum(EX_WbRegNum),
        .EX_Redirect(EX_Redirect),
        .PC_Stall(PC_Stall), .IFID_Stall(IFID_Stall), .IFID_CLR(IFID_CLR), .IDEX_CLR(IDEX_CLR),
        .MD_Start(MD_Start), .MD_IsDiv(MD_IsDiv), .MD_Busy(MD_Busy), .MD_Done(MD_Done),
        .StallCount(StallCount)
    );

    typedef struct {
        int   cyc;
        logic pc, ifid, ifidclr, idexclr, start, isdiv, busy, done;
        int   cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: an operation is described by its issue cycle and duration.
    bit   op_valid;
    int   op_issue;
    int   op_dur;
    bit   m_isdiv;
    int   m_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit occupied(int c);
        return op_valid && (c >= op_issue + 1) && (c <= op_issue + op_dur + 1);
    endfunction

    task automatic chk(string name, int c, int act, int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, req);
        end
    endtask

    // Monitor: every cycle presents a full output set, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("PC_Stall",   e.cyc, int'(PC_Stall),   int'(e.pc));
            chk("IFID_Stall", e.cyc, int'(IFID_Stall), int'(e.ifid));
            chk("IFID_CLR",   e.cyc, int'(IFID_CLR),   int'(e.ifidclr));
            chk("IDEX_CLR",   e.cyc, int'(IDEX_CLR),   int'(e.idexclr));
            chk("MD_Start",   e.cyc, int'(MD_Start),   int'(e.start));
            chk("MD_IsDiv",   e.cyc, int'(MD_IsDiv),   int'(e.isdiv));
            chk("MD_Busy",    e.cyc, int'(MD_Busy),    int'(e.busy));
            chk("MD_Done",    e.cyc, int'(MD_Done),    int'(e.done));
            chk("StallCount", e.cyc, int'(StallCount), e.cnt);
        end
    end

    initial begin
        exp_t e;
        bit   lu, mdh, stall, occ;
        CLR = 1'b1;
        ID_Rs = 5'd0; ID_Rt = 5'd0; EX_WbRegNum = 5'd0;
        ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_MulDiv = 1'b0; ID_IsDiv = 1'b0;
        ID_ReadHILO = 1'b0; EX_RegWrite = 1'b0; EX_MemtoReg = 1'b0; EX_Redirect = 1'b0;
        op_valid = 1'b0; op_issue = 0; op_dur = 0; m_isdiv = 1'b0; m_count = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #2;
            CLR         = (c == 0) || ($urandom_range(0, 79) == 0);
            ID_Rs       = 5'($urandom_range(0, 3));
            ID_Rt       = 5'($urandom_range(0, 3));
            ID_UseRs    = 1'($urandom_range(0, 1));
            ID_UseRt    = 1'($urandom_range(0, 1));
            ID_MulDiv   = ($urandom_range(0, 5) == 0);
            ID_IsDiv    = ($urandom_range(0, 3) == 0);
            ID_ReadHILO = ($urandom_range(0, 2) == 0);
            EX_RegWrite = ($urandom_range(0, 3) != 0);
            EX_MemtoReg = ($urandom_range(0, 2) == 0);
            EX_WbRegNum = 5'($urandom_range(0, 3));
            EX_Redirect = ($urandom_range(0, 7) == 0);

            if (CLR) begin
                op_valid = 1'b0;
                m_isdiv  = 1'b0;
                m_count  = 0;
            end

            occ = occupied(c);
            lu  = EX_RegWrite && EX_MemtoReg && (EX_WbRegNum != 5'd0) &&
                  ((ID_UseRs && ID_Rs == EX_WbRegNum) || (ID_UseRt && ID_Rt == EX_WbRegNum));
            mdh = occ && (ID_MulDiv || ID_ReadHILO);
            stall = lu || mdh;

            e.cyc     = c;
            e.ifidclr = EX_Redirect;
            e.idexclr = EX_Redirect || stall;
            e.pc      = !EX_Redirect && stall;
            e.ifid    = e.pc;
            e.start   = op_valid && (c == op_issue + 1);
            e.busy    = op_valid && (c >= op_issue + 1) && (c <= op_issue + op_dur);
            e.done    = op_valid && (c == op_issue + op_dur + 1);
            e.isdiv   = m_isdiv;
            e.cnt     = m_count;
            q.push_back(e);

            // Effects of the edge closing this cycle (none while CLR is held).
            if (!CLR) begin
                if (stall && !EX_Redirect && m_count < CNTMAX) m_count++;
                if (!occ && ID_MulDiv && !lu && !EX_Redirect) begin
                    op_valid = 1'b1;
                    op_issue = c;
                    op_dur   = ID_IsDiv ? DIVC : MULC;
                    m_isdiv  = ID_IsDiv;
                end
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", NCYC, q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
